// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
// The log2 helper sizes pointers and the occupancy counter.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int log2(input int n);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) res = i + 1;
    return res;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset.
// Read data follows raddr combinationally; no backpressure.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [log2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [log2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with level, almost flags and sticky error flags; 1-cycle read
// latency, or 0 with FIFO_FWFT_EN defined. Writes are dropped when full, reads when empty.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   r,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [log2(DEPTH):0]   level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = log2(DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_L    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_L    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   lvl_nxt;
  logic [WIDTH-1:0] rdata;

  assign rd_acc = r & ~empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign wr_acc = w & (~full | rd_acc);

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_comb begin
    lvl_nxt = level;
    if (wr_acc && !rd_acc)      lvl_nxt = level + LVL_ONE;
    else if (rd_acc && !wr_acc) lvl_nxt = level - LVL_ONE;
  end

  // Flags are computed from the next level so they line up with level itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      level        <= lvl_nxt;
      full         <= (lvl_nxt == DEPTH_L);
      empty        <= (lvl_nxt == '0);
      almost_full  <= (lvl_nxt >= AF_L);
      almost_empty <= (lvl_nxt <= AE_L);
      if (w && full && !rd_acc) overflow  <= 1'b1;
      if (r && empty)           underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so reset leaves out at 0.
  assign out       = empty ? '0 : rdata;
  assign out_valid = ~empty;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_acc;
      if (rd_acc) out <= rdata;
    end
  end
`endif

endmodule
